// File: rtl/scroll_sequencer.sv
// scroll_sequencer: scrolls a letter buffer across NUM_DIGITS 7-segment digits
// by fetching one ROM word per digit after each step and committing them together.
module scroll_sequencer #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 16,
  parameter int STEP_DIV   = 25_000_000,
  parameter int ROM_AW     = 5,
  parameter int SEG_W      = 7
) (
  input  logic                          clock_i,
  input  logic                          reset_n_i,
  input  logic                          run_i,
  input  logic                          step_req_i,
  input  logic [$clog2(MSG_LEN):0]      msg_len_i,
  input  logic                          wr_en_i,
  input  logic [$clog2(MSG_LEN)-1:0]    wr_addr_i,
  input  logic [ROM_AW-1:0]             wr_data_i,
  output logic [ROM_AW-1:0]             rom_addr_o,
  output logic                          rom_en_o,
  input  logic [SEG_W-1:0]              rom_data_i,
  output logic [NUM_DIGITS*SEG_W-1:0]   digits_o,
  output logic                          frame_valid_o,
  output logic                          busy_o,
  output logic [$clog2(MSG_LEN)-1:0]    offset_o
);
  localparam int AW = $clog2(MSG_LEN);
  localparam int LW = AW + 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(STEP_DIV);
  typedef enum logic [1:0] {IDLE, FETCH, LAST, COMMIT} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic pend_q, pend_d, tick;
  logic [AW-1:0] off_q, off_d, off_nx, rd_q, rd_d;
  logic [LW-1:0] len_q, len_d, len_eff;
  logic [DW-1:0] d_q, d_d;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] sh_q, sh_d, dig_q, dig_d;
  logic [MSG_LEN-1:0][ROM_AW-1:0] msg_q;
  assign len_eff = (msg_len_i == '0 || msg_len_i > LW'(MSG_LEN)) ? LW'(MSG_LEN) : msg_len_i;
  assign tick = run_i && pre_q == PW'(STEP_DIV - 1);
  assign pre_d = (run_i && !tick) ? pre_q + PW'(1) : '0;
  // a single compare covers both the normal wrap and an offset stranded past a shortened length
  assign off_nx = ({1'b0, off_q} + LW'(1) >= len_eff) ? '0 : off_q + AW'(1);
  assign rom_en_o = state_q == FETCH || state_q == LAST;
  assign rom_addr_o = state_q == FETCH ? msg_q[rd_q] : '0;
  assign frame_valid_o = state_q == COMMIT;
  assign busy_o = state_q != IDLE;
  assign digits_o = dig_q;
  assign offset_o = off_q;
  always_comb begin
    state_d = state_q;
    pend_d = pend_q | tick | step_req_i;
    off_d = off_q;
    rd_d = rd_q;
    len_d = len_q;
    d_d = d_q;
    sh_d = sh_q;
    dig_d = dig_q;
    case (state_q)
      IDLE: if (pend_q) begin
        pend_d = tick | step_req_i;
        off_d = off_nx;
        rd_d = off_nx;
        len_d = len_eff;
        d_d = '0;
        state_d = FETCH;
      end
      FETCH: begin
        if (d_q != '0) sh_d[d_q - DW'(1)] = rom_data_i;
        rd_d = ({1'b0, rd_q} + LW'(1) >= len_q) ? '0 : rd_q + AW'(1);
        d_d = d_q + DW'(1);
        state_d = d_q == DW'(NUM_DIGITS - 1) ? LAST : FETCH;
      end
      LAST: begin
        sh_d[NUM_DIGITS-1] = rom_data_i;
        state_d = COMMIT;
      end
      default: begin
        dig_d = sh_q;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      pre_q <= '0;
      pend_q <= 1'b0;
      off_q <= '0;
      rd_q <= '0;
      len_q <= LW'(MSG_LEN);
      d_q <= '0;
      sh_q <= '1;
      dig_q <= '1;
      msg_q <= '0;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      pend_q <= pend_d;
      off_q <= off_d;
      rd_q <= rd_d;
      len_q <= len_d;
      d_q <= d_d;
      sh_q <= sh_d;
      dig_q <= dig_d;
      if (wr_en_i) msg_q[wr_addr_i] <= wr_data_i;
    end
  end
endmodule
